// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM states, operation codes, PIN reset base.
// Types only; no latency or backpressure of its own.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PIN     = 3'd1,
    ST_MENU    = 3'd2,
    ST_SERVICE = 3'd3,
    ST_EJECT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_INQ = 2'd0,
    OP_DEP = 2'd1,
    OP_WDR = 2'd2,
    OP_PIN = 2'd3
  } op_t;

  localparam logic [15:0] PIN_BASE = 16'h1000;

  function automatic logic [15:0] reset_pin(input int idx);
    return PIN_BASE + 16'(idx);
  endfunction

endpackage

// File: rtl/atm_session_timer.sv
// Inactivity counter: timeout is high while running and the count sits at TIMEOUT_CYCLES-1.
// Timeout is a combinational decode of the count; clear takes effect on the next edge; no backpressure.
module atm_session_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = run && (count == LAST);

endmodule

// File: rtl/atm_multi_session_ctrl.sv
// Multi-account ATM session controller; ATM_SESSION_LIMIT_EN adds a per-session withdrawal cap.
// Op result one cycle after op_valid; qualifiers outside their state are ignored, no backpressure.
module atm_multi_session_ctrl
  import atm_pkg::*;
#(
  parameter int ACCT_COUNT     = 8,
  parameter int CARD_W         = 3,
  parameter int PSW_W          = 16,
  parameter int BAL_W          = 20,
  parameter int INIT_BALANCE   = 1000,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SESSION_LIMIT  = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_in,
  input  logic [CARD_W-1:0] card_number,
  input  logic              pin_valid,
  input  logic [PSW_W-1:0]  pin_in,
  input  logic              op_valid,
  input  logic [1:0]        operation,
  input  logic [BAL_W-1:0]  value,
  input  logic              svc_valid,
  input  logic              another_service,
  output logic [BAL_W-1:0]  balance_out,
  output logic              op_done,
  output logic              error,
  output logic              wrong_psw,
  output logic              card_locked,
  output logic              card_eject,
  output logic              busy
);

  localparam int AW = $clog2(MAX_TRIES + 1);
  localparam logic [CARD_W:0] ACCT_LIM = (CARD_W + 1)'(ACCT_COUNT);

  state_t state, state_nxt;

  logic              card_q;
  logic [CARD_W-1:0] acct;
  logic [BAL_W-1:0]  bal   [ACCT_COUNT];
  logic [PSW_W-1:0]  pin   [ACCT_COUNT];
  logic [AW-1:0]     tries [ACCT_COUNT];
  logic [ACCT_COUNT-1:0] locked;

  logic card_rise, card_hit_lock, card_bad;
  logic in_session, any_valid, timeout, expire;
  logic pin_match, last_try;
  logic [BAL_W-1:0] cur_bal, new_bal;
  logic [BAL_W:0]   dep_sum;
  logic op_ok, limit_ok;

  assign card_rise  = card_in & ~card_q;
  assign in_session = (state == ST_PIN) || (state == ST_MENU) || (state == ST_SERVICE);
  assign any_valid  = pin_valid | op_valid | svc_valid;
  assign expire     = timeout & ~any_valid;

  // Lock lookup by compare so an out-of-range card number never indexes past the table.
  always_comb begin
    card_hit_lock = 1'b0;
    for (int i = 0; i < ACCT_COUNT; i++) begin
      if (card_number == CARD_W'(i) && locked[i]) card_hit_lock = 1'b1;
    end
  end
  assign card_bad = ({1'b0, card_number} >= ACCT_LIM) || card_hit_lock;

  assign cur_bal   = bal[acct];
  assign pin_match = (pin_in == pin[acct]);
  assign last_try  = (tries[acct] == AW'(MAX_TRIES - 1));
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, value};

`ifdef ATM_SESSION_LIMIT_EN
  logic [BAL_W-1:0] sess_acc;
  logic [BAL_W:0]   sess_sum;
  assign sess_sum = {1'b0, sess_acc} + {1'b0, value};
  assign limit_ok = (sess_sum <= (BAL_W + 1)'(SESSION_LIMIT));
`else
  assign limit_ok = 1'b1;
`endif

  always_comb begin
    op_ok   = 1'b1;
    new_bal = cur_bal;
    case (op_t'(operation))
      OP_DEP: begin
        op_ok   = ~dep_sum[BAL_W];
        new_bal = op_ok ? dep_sum[BAL_W-1:0] : cur_bal;
      end
      OP_WDR: begin
        op_ok   = (value <= cur_bal) && limit_ok;
        new_bal = op_ok ? (cur_bal - value) : cur_bal;
      end
      default: ;
    endcase
  end

  atm_session_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (in_session),
    .clear  (any_valid || (state_nxt != state)),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Card removal outranks every qualifier; a live qualifier outranks the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (card_rise) state_nxt = card_bad ? ST_EJECT : ST_PIN;
      ST_PIN: begin
        if (!card_in)        state_nxt = ST_IDLE;
        else if (pin_valid) begin
          if (pin_match)     state_nxt = ST_MENU;
          else if (last_try) state_nxt = ST_EJECT;
        end else if (expire) state_nxt = ST_EJECT;
      end
      ST_MENU: begin
        if (!card_in)       state_nxt = ST_IDLE;
        else if (op_valid)  state_nxt = ST_SERVICE;
        else if (expire)    state_nxt = ST_EJECT;
      end
      ST_SERVICE: begin
        if (!card_in)       state_nxt = ST_IDLE;
        else if (svc_valid) state_nxt = another_service ? ST_MENU : ST_EJECT;
        else if (expire)    state_nxt = ST_EJECT;
      end
      ST_EJECT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    card_eject = (state == ST_EJECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_q      <= 1'b0;
      acct        <= '0;
      balance_out <= '0;
      op_done     <= 1'b0;
      error       <= 1'b0;
      wrong_psw   <= 1'b0;
      card_locked <= 1'b0;
      locked      <= '0;
      for (int i = 0; i < ACCT_COUNT; i++) begin
        bal[i]   <= BAL_W'(INIT_BALANCE);
        pin[i]   <= PSW_W'(reset_pin(i));
        tries[i] <= '0;
      end
`ifdef ATM_SESSION_LIMIT_EN
      sess_acc <= '0;
`endif
    end else begin
      card_q      <= card_in;
      op_done     <= 1'b0;
      error       <= 1'b0;
      wrong_psw   <= 1'b0;
      card_locked <= 1'b0;
      case (state)
        ST_IDLE: if (card_rise) begin
          acct  <= card_number;
          error <= card_bad;
`ifdef ATM_SESSION_LIMIT_EN
          sess_acc <= '0;
`endif
        end
        ST_PIN: if (card_in && pin_valid) begin
          if (pin_match) begin
            tries[acct] <= '0;
          end else begin
            wrong_psw   <= 1'b1;
            tries[acct] <= tries[acct] + 1'b1;
            if (last_try) begin
              locked[acct] <= 1'b1;
              card_locked  <= 1'b1;
            end
          end
        end
        ST_MENU: if (card_in && op_valid) begin
          if (op_ok) begin
            op_done     <= 1'b1;
            balance_out <= new_bal;
            bal[acct]   <= new_bal;
            if (op_t'(operation) == OP_PIN) pin[acct] <= value[PSW_W-1:0];
`ifdef ATM_SESSION_LIMIT_EN
            if (op_t'(operation) == OP_WDR) sess_acc <= sess_sum[BAL_W-1:0];
`endif
          end else begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_multi_session_ctrl.sv
// Self-checking bench: directed session scenarios plus randomized sessions against an account-level model.
module tb_atm_multi_session_ctrl;

  localparam int ACCT = 6;
  localparam int CW   = 3;
  localparam int PW   = 16;
  localparam int BW   = 20;
  localparam int TMO  = 40;
  localparam int LIM  = 500;

  logic          clk = 1'b0;
  logic          rst;
  logic          card_in;
  logic [CW-1:0] card_number;
  logic          pin_valid;
  logic [PW-1:0] pin_in;
  logic          op_valid;
  logic [1:0]    operation;
  logic [BW-1:0] value;
  logic          svc_valid;
  logic          another_service;
  logic [BW-1:0] balance_out;
  logic          op_done, error, wrong_psw, card_locked, card_eject, busy;

  int n_checks = 0;
  int n_fail   = 0;

  longint        m_bal [ACCT];
  logic [PW-1:0] m_pin [ACCT];
  logic [BW-1:0] m_out;
  longint        m_sess;

  always #5 clk = ~clk;

  atm_multi_session_ctrl #(
    .ACCT_COUNT(ACCT), .CARD_W(CW), .PSW_W(PW), .BAL_W(BW), .INIT_BALANCE(1000),
    .MAX_TRIES(3), .TIMEOUT_CYCLES(TMO), .SESSION_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
    .pin_valid(pin_valid), .pin_in(pin_in), .op_valid(op_valid), .operation(operation),
    .value(value), .svc_valid(svc_valid), .another_service(another_service),
    .balance_out(balance_out), .op_done(op_done), .error(error), .wrong_psw(wrong_psw),
    .card_locked(card_locked), .card_eject(card_eject), .busy(busy)
  );

  task automatic model_reset();
    for (int i = 0; i < ACCT; i++) begin
      m_bal[i] = 1000;
      m_pin[i] = 16'h1000 + 16'(i);
    end
    m_out  = '0;
    m_sess = 0;
  endtask

  // Account-level arithmetic: what the customer should see for one operation.
  task automatic model_apply(input int a, input logic [1:0] op, input logic [BW-1:0] v, output bit ok);
    longint maxv;
    maxv = (longint'(1) << BW) - 1;
    ok = 1'b1;
    case (op)
      2'd1: if (m_bal[a] + longint'(v) > maxv) ok = 1'b0;
            else m_bal[a] = m_bal[a] + longint'(v);
      2'd2: begin
        if (longint'(v) > m_bal[a]) ok = 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
        if (m_sess + longint'(v) > LIM) ok = 1'b0;
`endif
        if (ok) begin
          m_bal[a] = m_bal[a] - longint'(v);
          m_sess   = m_sess + longint'(v);
        end
      end
      2'd3: m_pin[a] = v[PW-1:0];
      default: ;
    endcase
    if (ok) m_out = BW'(m_bal[a]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_card();
    card_in = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic insert(input int c);
    card_number = CW'(c);
    card_in     = 1'b1;
    m_sess      = 0;
    cyc();
  endtask

  task automatic enter_pin(input logic [PW-1:0] p);
    pin_valid = 1'b1;
    pin_in    = p;
    cyc();
    pin_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [BW-1:0] v);
    op_valid  = 1'b1;
    operation = op;
    value     = v;
    cyc();
    op_valid  = 1'b0;
  endtask

  task automatic svc(input bit a);
    svc_valid       = 1'b1;
    another_service = a;
    cyc();
    svc_valid       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; card_in = 1'b0; card_number = '0; pin_valid = 1'b0; pin_in = '0;
    op_valid = 1'b0; operation = '0; value = '0; svc_valid = 1'b0; another_service = 1'b0;
    model_reset();
    cyc();
    cyc();
    n_checks++;
    if ({balance_out, op_done, error, wrong_psw, card_locked, card_eject, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got bal=%0d flags=%b, expected all zero", balance_out,
               {op_done, error, wrong_psw, card_locked, card_eject, busy});
    end
    rst = 1'b0;
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_withdraw_session();
    bit ok;
    bit seen;
    idle_card();
    insert(2);
    n_checks++;
    if ({error, card_eject, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL insert_valid: err/eject/busy=%b expected 001", {error, card_eject, busy});
    end
    enter_pin(16'h1002);
    n_checks++;
    if ({wrong_psw, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL pin_ok: wrong_psw/busy=%b expected 01", {wrong_psw, busy});
    end
    model_apply(2, 2'd2, 20'd300, ok);
    do_op(2'd2, 20'd300);
    n_checks++;
    if ({op_done, error, balance_out} !== {1'b1, 1'b0, 20'd700}) begin
      n_fail++;
      $display("FAIL withdraw_300: done=%b err=%b bal=%0d expected 1 0 700", op_done, error, balance_out);
    end
    svc(1'b0);
    n_checks++;
    if ({card_eject, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL finish_eject: eject/busy=%b expected 11", {card_eject, busy});
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (busy || card_eject) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_reentry: busy/eject seen=%b expected 0", seen);
    end
  endtask

  task automatic test_lockout();
    idle_card();
    insert(5);
    for (int t = 0; t < 3; t++) begin
      enter_pin(16'h2222);
      n_checks++;
      if ({wrong_psw, card_locked, card_eject} !== ((t == 2) ? 3'b111 : 3'b100)) begin
        n_fail++;
        $display("FAIL wrong_pin_%0d: wrong/locked/eject=%b expected %b", t,
                 {wrong_psw, card_locked, card_eject}, (t == 2) ? 3'b111 : 3'b100);
      end
    end
    cyc();
    idle_card();
    insert(5);
    n_checks++;
    if ({error, card_eject, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL locked_reinsert: err/eject/busy=%b expected 111", {error, card_eject, busy});
    end
    cyc();
  endtask

  task automatic test_arith_errors();
    bit ok;
    idle_card();
    insert(0);
    enter_pin(16'h1000);
    model_apply(0, 2'd0, 20'd0, ok);
    do_op(2'd0, 20'd0);
    n_checks++;
    if ({op_done, error, balance_out} !== {1'b1, 1'b0, 20'd1000}) begin
      n_fail++;
      $display("FAIL inquiry: done=%b err=%b bal=%0d expected 1 0 1000", op_done, error, balance_out);
    end
    svc(1'b1);
    model_apply(0, 2'd1, 20'd1048000, ok);
    do_op(2'd1, 20'd1048000);
    n_checks++;
    if ({op_done, error, balance_out} !== {1'b0, 1'b1, 20'd1000}) begin
      n_fail++;
      $display("FAIL deposit_overflow: done=%b err=%b bal=%0d expected 0 1 1000", op_done, error, balance_out);
    end
    svc(1'b1);
    model_apply(0, 2'd2, 20'd1001, ok);
    do_op(2'd2, 20'd1001);
    n_checks++;
    if ({op_done, error} !== 2'b01) begin
      n_fail++;
      $display("FAIL withdraw_over: done/err=%b expected 01", {op_done, error});
    end
    svc(1'b1);
    model_apply(0, 2'd2, 20'd1000, ok);
    do_op(2'd2, 20'd1000);
    n_checks++;
    if ({op_done, error, balance_out} !== {1'b1, 1'b0, 20'd0}) begin
      n_fail++;
      $display("FAIL withdraw_exact: done=%b err=%b bal=%0d expected 1 0 0", op_done, error, balance_out);
    end
    svc(1'b0);
    cyc();
  endtask

  task automatic test_invalid_and_removal();
    bit ok;
    for (int c = ACCT; c < 8; c++) begin
      idle_card();
      insert(c);
      n_checks++;
      if ({error, card_eject, busy} !== 3'b111) begin
        n_fail++;
        $display("FAIL invalid_card_%0d: err/eject/busy=%b expected 111", c, {error, card_eject, busy});
      end
      cyc();
    end
    idle_card();
    insert(1);
    card_in = 1'b0;
    pin_valid = 1'b1; pin_in = 16'h1001;
    cyc();
    pin_valid = 1'b0;
    n_checks++;
    if ({wrong_psw, card_eject, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL remove_in_pin: wrong/eject/busy=%b expected 000", {wrong_psw, card_eject, busy});
    end
    insert(1);
    enter_pin(16'h1001);
    card_in = 1'b0;
    op_valid = 1'b1; operation = 2'd2; value = 20'd100;
    cyc();
    op_valid = 1'b0;
    n_checks++;
    if ({op_done, error, card_eject, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL remove_in_menu: done/err/eject/busy=%b expected 0000", {op_done, error, card_eject, busy});
    end
    insert(1);
    enter_pin(16'h1001);
    model_apply(1, 2'd0, 20'd0, ok);
    do_op(2'd0, 20'd0);
    n_checks++;
    if ({op_done, balance_out} !== {1'b1, 20'd1000}) begin
      n_fail++;
      $display("FAIL balance_after_removal: done=%b bal=%0d expected 1 1000", op_done, balance_out);
    end
    svc(1'b0);
    cyc();
  endtask

  task automatic test_timeout();
    bit early;
    bit ok;
    idle_card();
    insert(3);
    enter_pin(16'h1003);
    early = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      cyc();
      if (card_eject || !busy) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL menu_timeout_early: premature exit=%b expected 0", early);
    end
    cyc();
    n_checks++;
    if ({card_eject, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL menu_timeout: eject/busy=%b expected 11", {card_eject, busy});
    end
    cyc();
    idle_card();
    insert(3);
    for (int i = 1; i < TMO; i++) cyc();
    enter_pin(16'h1003);
    n_checks++;
    if ({card_eject, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL pin_wins_timeout: eject/busy=%b expected 01", {card_eject, busy});
    end
    model_apply(3, 2'd0, 20'd0, ok);
    do_op(2'd0, 20'd0);
    n_checks++;
    if (op_done !== 1'b1) begin
      n_fail++;
      $display("FAIL menu_after_timeout_pin: op_done=%b expected 1", op_done);
    end
    svc(1'b0);
    cyc();
  endtask

  task automatic test_pin_change_and_limit();
    bit ok;
    idle_card();
    insert(4);
    enter_pin(16'h1004);
    model_apply(4, 2'd3, 20'h0BEEF, ok);
    do_op(2'd3, 20'h0BEEF);
    n_checks++;
    if ({op_done, error, balance_out} !== {1'b1, 1'b0, 20'd1000}) begin
      n_fail++;
      $display("FAIL pin_change: done=%b err=%b bal=%0d expected 1 0 1000", op_done, error, balance_out);
    end
    svc(1'b0);
    cyc();
    idle_card();
    insert(4);
    enter_pin(16'h1004);
    n_checks++;
    if (wrong_psw !== 1'b1) begin
      n_fail++;
      $display("FAIL old_pin_rejected: wrong_psw=%b expected 1", wrong_psw);
    end
    enter_pin(16'hBEEF);
    n_checks++;
    if ({wrong_psw, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL new_pin_accepted: wrong/busy=%b expected 01", {wrong_psw, busy});
    end
    model_apply(4, 2'd2, 20'd300, ok);
    do_op(2'd2, 20'd300);
    n_checks++;
    if ({op_done, balance_out} !== {1'b1, 20'd700}) begin
      n_fail++;
      $display("FAIL limit_wdr_300: done=%b bal=%0d expected 1 700", op_done, balance_out);
    end
    svc(1'b1);
    model_apply(4, 2'd2, 20'd250, ok);
    do_op(2'd2, 20'd250);
    n_checks++;
`ifdef ATM_SESSION_LIMIT_EN
    if ({op_done, error, balance_out} !== {1'b0, 1'b1, 20'd700}) begin
      n_fail++;
      $display("FAIL limit_wdr_250: done=%b err=%b bal=%0d expected 0 1 700", op_done, error, balance_out);
    end
`else
    if ({op_done, error, balance_out} !== {1'b1, 1'b0, 20'd450}) begin
      n_fail++;
      $display("FAIL limit_wdr_250: done=%b err=%b bal=%0d expected 1 0 450", op_done, error, balance_out);
    end
`endif
    svc(1'b0);
    cyc();
  endtask

  task automatic test_random_sessions();
    bit ok;
    int a, nops;
    logic [1:0] op;
    logic [BW-1:0] v;
    for (int s = 0; s < 16; s++) begin
      a = $urandom_range(0, 4);
      idle_card();
      insert(a);
      if ($urandom_range(0, 2) == 0) begin
        enter_pin(m_pin[a] ^ 16'h0001);
        n_checks++;
        if ({wrong_psw, card_locked} !== 2'b10) begin
          n_fail++;
          $display("FAIL rand_wrong_pin s%0d: wrong/locked=%b expected 10", s, {wrong_psw, card_locked});
        end
      end
      enter_pin(m_pin[a]);
      nops = $urandom_range(1, 4);
      for (int k = 0; k < nops; k++) begin
        op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: v = BW'($urandom_range(0, 400));
          1: v = BW'($urandom_range(0, 1500));
          2: v = 20'hFFFFF - BW'($urandom_range(0, 2000));
          default: v = BW'($urandom);
        endcase
        model_apply(a, op, v, ok);
        do_op(op, v);
        n_checks++;
        if ({op_done, error, balance_out} !== {ok, ~ok, m_out}) begin
          n_fail++;
          $display("FAIL rand_op s%0d k%0d op%0d val=%0d: done=%b err=%b bal=%0d expected %b %b %0d",
                   s, k, op, v, op_done, error, balance_out, ok, ~ok, m_out);
        end
        svc(k != nops - 1);
      end
      n_checks++;
      if (card_eject !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_eject s%0d: card_eject=%b expected 1", s, card_eject);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_session();
    bit ok;
    idle_card();
    insert(2);
    enter_pin(m_pin[2]);
    do_op(2'd1, 20'd55);
    rst = 1'b1;
    #2;
    n_checks++;
    if ({balance_out, op_done, error, card_eject, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: bal=%0d flags=%b expected all zero", balance_out,
               {op_done, error, card_eject, busy});
    end
    card_in = 1'b0;
    cyc();
    rst = 1'b0;
    model_reset();
    cyc();
    insert(5);
    n_checks++;
    if ({error, card_eject, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL lock_cleared: err/eject/busy=%b expected 001", {error, card_eject, busy});
    end
    enter_pin(16'h1005);
    model_apply(5, 2'd0, 20'd0, ok);
    do_op(2'd0, 20'd0);
    n_checks++;
    if ({wrong_psw, op_done, balance_out} !== {1'b0, 1'b1, 20'd1000}) begin
      n_fail++;
      $display("FAIL storage_reinit: wrong=%b done=%b bal=%0d expected 0 1 1000", wrong_psw, op_done, balance_out);
    end
    svc(1'b0);
    cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_withdraw_session();
    test_lockout();
    test_arith_errors();
    test_invalid_and_removal();
    test_timeout();
    test_pin_change_and_limit();
    test_random_sessions();
    test_reset_mid_session();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_multi_session_ctrl.md
Name: atm_multi_session_ctrl

Overview:
- Parametrised next-generation ATM transaction controller.
- Merges card handling, session FSM and inactivity timer into one block.
- Supports ACCT_COUNT accounts with flop-based balance and PIN storage, per-account wrong-PIN lockout, PIN change and an explicit card-eject handshake.
- Sits between the card reader/keypad front end and the display/dispenser logic.

Parameters:
ACCT_COUNT, 8, number of accounts; card_number >= ACCT_COUNT is invalid
CARD_W, 3, card number width; must satisfy 2^CARD_W >= ACCT_COUNT
PSW_W, 16, PIN width
BAL_W, 20, balance/value width
INIT_BALANCE, 1000, reset balance of every account
MAX_TRIES, 3, consecutive wrong PINs before lockout
TIMEOUT_CYCLES, 1000, inactivity cycles before forced eject
SESSION_LIMIT, 500, per-session withdrawal cap (only used when the optional feature is enabled)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
card_in  input  1  level: card physically present
card_number  input  CARD_W  account index, sampled on card insertion
pin_valid  input  1  pin_in qualifier
pin_in  input  PSW_W  entered PIN
op_valid  input  1  operation/value qualifier
operation  input  2  0 inquiry, 1 deposit, 2 withdraw, 3 PIN change (value[PSW_W-1:0] is the new PIN)
value  input  BAL_W  amount or new PIN
svc_valid  input  1  another_service qualifier
another_service  input  1  1 = return to menu, 0 = finish
balance_out  output  BAL_W  balance of the active account after the last operation
op_done  output  1  1-cycle pulse: operation committed
error  output  1  1-cycle pulse: invalid card, insufficient funds, overflow or limit exceeded
wrong_psw  output  1  1-cycle pulse: PIN mismatch
card_locked  output  1  1-cycle pulse: account locked out
card_eject  output  1  1-cycle pulse: eject card
busy  output  1  high in any state except IDLE

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - Every balance = INIT_BALANCE; PIN[i] = 16'h1000 + i, truncated to PSW_W.
  - Attempt counters and lock flags cleared.
- Reset mid-session discards the session; storage reinitialises.
- States: IDLE, PIN, MENU, SERVICE, EJECT.
- IDLE:
  - Registered rising edge of card_in latches card_number.
  - Invalid or locked account: error pulse, go to EJECT.
  - Otherwise go to PIN.
- PIN, on pin_valid:
  - Match: attempts[acct] = 0, go to MENU.
  - Mismatch: wrong_psw pulse and attempts++.
  - If attempts reaches MAX_TRIES: set lock[acct], card_locked pulse, go to EJECT.
  - Lock persists until rst.
- MENU, on op_valid: result registered; op_done or error asserted the cycle after the op_valid sample, then go to SERVICE.
  - Inquiry: balance_out = balance.
  - Deposit: compute with BAL_W+1 bits. Carry set means error and balance unchanged.
  - Withdraw: value > balance means error and balance unchanged; otherwise subtract.
  - PIN change: always succeeds.
  - Every success pulses op_done and updates balance_out.
- SERVICE, on svc_valid:
  - another_service = 1: go to MENU.
  - another_service = 0: go to EJECT.
- EJECT: card_eject pulses for 1 cycle, then go to IDLE. A new session requires a fresh rising edge of card_in.
- Card removal:
  - card_in low in PIN, MENU or SERVICE: immediate return to IDLE with no eject pulse.
  - This wins over a simultaneous op_valid, pin_valid or svc_valid; no commit happens.
- Inactivity timer:
  - Counts in PIN, MENU and SERVICE.
  - Cleared on any state change or any *_valid input.
  - Reaching TIMEOUT_CYCLES-1 forces EJECT.
  - Timeout and a valid input in the same cycle: the input wins.
- Only one *_valid input is honoured per state. Qualifiers that do not belong to the current state are ignored.

Optional Feature:
- Macro ATM_SESSION_LIMIT_EN.
- Defined:
  - Per-session accumulator of successful withdrawals, cleared when entering PIN.
  - A withdraw where accumulator + value > SESSION_LIMIT gives error, with no balance change.
- Undefined: no accumulator exists; SESSION_LIMIT is unused.

Decomposition:
- Package atm_pkg:
  - State encoding.
  - Op codes OP_INQ, OP_DEP, OP_WDR, OP_PIN.
  - PIN reset base 16'h1000.
- Sub-module atm_session_timer: parametrised inactivity counter.
  - Inputs: clk, rst, run, clear.
  - Output: timeout.

Test Plan:
1. Insert card 2, pin 16'h1002, withdraw 300, another_service=0 -> op_done, balance_out=700, then card_eject pulse, then IDLE.
2. Card 5, three wrong PINs -> three wrong_psw pulses, card_locked on the third, eject. Reinsert card 5 -> error plus eject without entering PIN.
3. Deposit 1048000 into balance 1000 -> error, balance stays 1000. Withdraw 1001 -> error.
4. Card_number 7 with ACCT_COUNT=6 -> error plus eject. Card_in dropped in MENU together with op_valid -> IDLE, balance unchanged.
5. No input for TIMEOUT_CYCLES in MENU -> card_eject. A pin_valid on the timeout cycle is honoured instead.
6. PIN change to 16'hBEEF, eject, reinsert with the old PIN -> wrong_psw; with 16'hBEEF -> MENU. With ATM_SESSION_LIMIT_EN, withdrawals 300 then 250 -> op_done then error.
